// File: rtl/gradient_window_gen_pkg.sv
// Shared widths, window-entry type and slot indices for the 3x3 gradient window
// that sits between the Sobel stage and non-maximum suppression.
package gradient_window_gen_pkg;

  localparam int GRAD_MAG_W = 11;
  localparam int GRAD_DIR_W = 2;
  localparam int WIN_SIZE   = 9;
  localparam int ENTRY_W    = GRAD_MAG_W + GRAD_DIR_W;

  localparam int WIN_MAG_W = GRAD_MAG_W * WIN_SIZE;
  localparam int WIN_DIR_W = GRAD_DIR_W * WIN_SIZE;

  typedef struct packed {
    logic [GRAD_DIR_W-1:0] dir;
    logic [GRAD_MAG_W-1:0] mag;
  } win_entry_t;

  // Slot k = 3*row + col; row 0 is the oldest line, col 2 the newest pixel.
  localparam int WIN_TL     = 0;
  localparam int WIN_TC     = 1;
  localparam int WIN_TR     = 2;
  localparam int WIN_ML     = 3;
  localparam int WIN_CENTER = 4;
  localparam int WIN_MR     = 5;
  localparam int WIN_BL     = 6;
  localparam int WIN_BC     = 7;
  localparam int WIN_BR     = 8;

  function automatic logic [WIN_MAG_W-1:0] pack_mag(input win_entry_t [WIN_SIZE-1:0] w);
    logic [WIN_MAG_W-1:0] m;
    m = '0;
    for (int k = 0; k < WIN_SIZE; k++) m[GRAD_MAG_W*k +: GRAD_MAG_W] = w[k].mag;
    return m;
  endfunction

  function automatic logic [WIN_DIR_W-1:0] pack_dir(input win_entry_t [WIN_SIZE-1:0] w);
    logic [WIN_DIR_W-1:0] d;
    d = '0;
    for (int k = 0; k < WIN_SIZE; k++) d[GRAD_DIR_W*k +: GRAD_DIR_W] = w[k].dir;
    return d;
  endfunction

endpackage

// File: rtl/gradient_window_gen_line.sv
// One row of gradient pixels; the read port sees the old contents so the
// caller gets the previous row's pixel while the current one is stored.
module gradient_line_buffer
  import gradient_window_gen_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en,
  input  logic [AW-1:0]      addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data
);

  // Contents are intentionally unreset: every location is rewritten before use.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) mem_q[addr] <= wr_data;
  end

endmodule

// File: rtl/gradient_window_gen.sv
// Streaming 3x3 magnitude/direction window generator. One pixel per cycle in,
// one registered window per interior pixel out, one cycle later.
module gradient_window_gen
  import gradient_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [GRAD_MAG_W-1:0] in_magnitude,
  input  logic [GRAD_DIR_W-1:0] in_direction,
  output logic [WIN_MAG_W-1:0]  gradient_magnitude,
  output logic [WIN_DIR_W-1:0]  gradient_direction,
  output logic                  gradient_mag_valid,
  output logic                  gradient_dir_valid,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  if (IMG_WIDTH < 3) begin : g_bad_width
    $error("gradient_window_gen: IMG_WIDTH must be >= 3");
  end
  if (IMG_HEIGHT < 3) begin : g_bad_height
    $error("gradient_window_gen: IMG_HEIGHT must be >= 3");
  end

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          last_col, last_row;

  win_entry_t [WIN_SIZE-1:0] win_q, win_d;
  logic                      mag_valid_q, mag_valid_d;
  logic                      frame_done_q, frame_done_d;

  win_entry_t         in_pix;
  logic [ENTRY_W-1:0] lb0_rd, lb1_rd;

  assign in_pix = '{dir: in_direction, mag: in_magnitude};

  // Start-of-frame overrides the counters for the pixel that carries it.
  always_comb begin
    pos_col  = in_sof ? '0 : col_q;
    pos_row  = in_sof ? '0 : row_q;
    last_col = (pos_col == CW'(IMG_WIDTH - 1));
    last_row = (pos_row == RW'(IMG_HEIGHT - 1));
  end

  gradient_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
    .clk     (clk),
    .en      (in_valid),
    .addr    (pos_col),
    .wr_data (in_pix),
    .rd_data (lb0_rd)
  );

  gradient_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk     (clk),
    .en      (in_valid),
    .addr    (pos_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    mag_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[WIN_TR] = win_entry_t'(lb1_rd);
      win_d[WIN_MR] = win_entry_t'(lb0_rd);
      win_d[WIN_BR] = in_pix;

      // Columns 0/1 flush the previous row's stale columns without a window.
      mag_valid_d  = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      frame_done_d = last_row && last_col;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      mag_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      mag_valid_q  <= mag_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gradient_magnitude = pack_mag(win_q);
  assign gradient_direction = pack_dir(win_q);
  assign gradient_mag_valid = mag_valid_q;
  assign gradient_dir_valid = mag_valid_q;
  assign frame_done         = frame_done_q;

endmodule

// File: doc/gradient_window_gen.md
Name: gradient_window_gen

Overview:
- Streaming 3x3 window generator between the gradient (Sobel magnitude/direction) stage and non-maximum suppression.
- Accepts one gradient pixel per cycle in raster order and buffers two previous rows in line buffers.
- Emits the packed 3x3 magnitude and direction windows exactly as the NMS stage consumes them.
- Produces one window per interior pixel.

Parameters:
- IMG_WIDTH, 640, pixels per row (>=3)
- IMG_HEIGHT, 480, rows per frame (>=3)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  pixel present this cycle
- in_sof  input  1  first pixel of frame; qualified by in_valid
- in_magnitude  input  11  gradient magnitude of pixel
- in_direction  input  2  quantised gradient direction of pixel
- gradient_magnitude  output  99  3x3 magnitude window, packed
- gradient_direction  output  18  3x3 direction window, packed
- gradient_mag_valid  output  1  window valid pulse
- gradient_dir_valid  output  1  same as gradient_mag_valid
- frame_done  output  1  pulse with last window of frame

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - col/row counters = 0.
  - All window registers = 0, so both gradient_magnitude and gradient_direction = 0.
  - gradient_mag_valid, gradient_dir_valid and frame_done = 0.
  - Line-buffer contents are not reset; they are never exposed before being rewritten in the current frame.
- Window packing:
  - Slot k = 3*r + c. r=0 is the oldest row (top), r=2 is the current row. c=0 is the oldest column (left), c=2 is the newest pixel.
  - Magnitude slot k occupies bits [11k+10:11k]. Centre is k=4, bits [54:44].
  - Direction slot k occupies bits [2k+1:2k]. Centre is bits [9:8].
- Accepted pixel: in_valid=1. No backpressure; every valid pixel is consumed.
- Position: the pixel's position (R,C) is the current counter value, except when in_sof=1, where it is forced to (0,0).
- On each accepted pixel, at the next clk edge:
  - Line buffer 0 is read at address C, then written with the incoming pixel (read-before-write). Line buffer 1 is read at address C, then written with line buffer 0's old data.
  - The window shifts left one column. The new column c=2 gets r0 = lb1 old data, r1 = lb0 old data, r2 = incoming pixel.
  - gradient_mag_valid and gradient_dir_valid are set to (R>=2 && C>=2).
  - frame_done is set to (R==IMG_HEIGHT-1 && C==IMG_WIDTH-1).
  - Counters advance:
    - C==IMG_WIDTH-1 wraps C to 0 and increments R.
    - R==IMG_HEIGHT-1 at the last column wraps R to 0. Back-to-back frames work without in_sof.
- Latency: one cycle. The window for centre pixel (R-1,C-1) is valid the cycle after pixel (R,C) is accepted.
- Valid pulse:
  - Valids are high for one cycle per qualifying pixel.
  - Cycles with in_valid=0 drive valids and frame_done to 0 and leave the window and counters unchanged.
- Output count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. Border pixels produce no window.
- Row-boundary columns:
  - Columns C=0 and C=1 still shift into the window but never assert valid.
  - Stale columns from the previous row are therefore flushed before the first valid window of each row.
- in_sof mid-frame: restarts the frame at (0,0) with that pixel. No window is emitted until new row 2, column 2.
- rst mid-frame: counters return to (0,0) and outputs clear next cycle. The following pixel is treated as (0,0) even if in_sof=0.
- No combinational path from inputs to outputs.

Decomposition:
- definitions_pkg adds:
  - GRAD_MAG_W=11 and GRAD_DIR_W=2.
  - WIN_SIZE=9.
  - A packed typedef for one window entry, {dir, mag}, 13 bits.
  - Slot index constants WIN_CENTER=4 and the neighbour indices 0..8.
- Sub-module gradient_line_buffer:
  - One row of depth IMG_WIDTH, width 13.
  - Synchronous read-before-write at a single address, enable = in_valid.
  - Instantiated twice and chained.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, in_valid continuous, in_sof on the first pixel, mag=10*R+C, dir=(R+C)%4.
  - Exactly 4 valid pulses, the first one cycle after pixel (2,2).
  - First window: [54:44]=11, [10:0]=0, [98:88]=22, [65:55]=12, [43:33]=10, [9:8]=2.
- Same frame with in_valid low every other cycle: identical 4 windows in the same order. Valids never high on idle-follow cycles.
- Two frames back-to-back, in_sof only on the first:
  - 8 windows total.
  - frame_done pulses with the 4th and 8th windows.
  - The second frame's first window equals the first frame's.
- in_sof asserted at pixel (2,1) of frame 1, then a full frame: no valid before new (2,2). The next window's centre = new-frame pixel (1,1).
- rst high for one cycle after pixel (3,0): all outputs 0 the next cycle. The following 16 pixels yield 4 correct windows.
- IMG_WIDTH=640, IMG_HEIGHT=480 random stream vs reference model:
  - All 638*478 windows match bit-for-bit.
  - gradient_mag_valid==gradient_dir_valid on every cycle.
